// File: rtl/input_vc_controller_base_pkg.sv
// Shared definitions for the input VC controller: link/flit format macros,
// VC state encodings, counter types and flit-type helpers.
`ifndef DW
`define DW 8
`endif
`ifndef BUF_DEPTH
`define BUF_DEPTH 4
`endif
`ifndef BUF_DEPTH_LOG
`define BUF_DEPTH_LOG 2
`endif
`ifndef CREDIT_LBOUND
`define CREDIT_LBOUND 1
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b00
`endif
`ifndef TAIL
`define TAIL 2'b10
`endif
`ifndef VC_IDLE
`define VC_IDLE 2'd0
`endif
`ifndef VC_WAIT_VA
`define VC_WAIT_VA 2'd1
`endif
`ifndef VC_ACTIVE
`define VC_ACTIVE 2'd2
`endif

package input_vc_controller_base_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = `VC_IDLE,
    ST_WAIT_VA = `VC_WAIT_VA,
    ST_ACTIVE  = `VC_ACTIVE
  } vc_state_e;

  typedef logic [`BUF_DEPTH_LOG-1:0] ptr_t;
  typedef logic [`BUF_DEPTH_LOG:0]   cnt_t;

  function automatic logic [1:0] flit_type(input logic [`DW-1:0] f);
    return f[`DW-3:`DW-4];
  endfunction

  // A HEAD+TAIL single-flit packet carries both type bits.
  function automatic logic is_head(input logic [1:0] t);
    return (t & `HEAD) == `HEAD;
  endfunction

  function automatic logic is_tail(input logic [1:0] t);
    return (t & `TAIL) == `TAIL;
  endfunction

endpackage

// File: rtl/input_vc_controller_base_fifo.sv
// vc_flit_fifo: BUF_DEPTH-entry flit store with wrapping pointers, occupancy
// count and same-cycle push/pop. Drop/underflow flags exist with INPUT_VC_OVF_CHK_EN.
module vc_flit_fifo
  import input_vc_controller_base_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  input  logic           push,
  input  logic           pop,
  input  logic [`DW-1:0] din,
  output logic [`DW-1:0] dout,
  output logic           empty
`ifdef INPUT_VC_OVF_CHK_EN
  ,
  output logic           push_drop,
  output logic           pop_empty
`endif
);

  localparam ptr_t LAST_PTR = ptr_t'(`BUF_DEPTH - 1);
  localparam cnt_t FULL_CNT = cnt_t'(`BUF_DEPTH);

  logic [`DW-1:0] mem_r [`BUF_DEPTH];
  ptr_t           wr_ptr_r;
  ptr_t           rd_ptr_r;
  cnt_t           count_r;
  logic           full_s;
  logic           do_push_s;
  logic           do_pop_s;

  // Occupancy flags and effective push/pop; a full FIFO still accepts when popping.
  always_comb begin
    full_s    = (count_r == FULL_CNT);
    empty     = (count_r == cnt_t'(0));
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full_s | do_pop_s);
    dout      = mem_r[rd_ptr_r];
  end

`ifdef INPUT_VC_OVF_CHK_EN
  // Protocol-violation flags for the sticky error bits in the top.
  always_comb begin
    push_drop = push & full_s & ~do_pop_s;
    pop_empty = pop & empty;
  end
`endif

  // Storage write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < `BUF_DEPTH; i++) begin
        mem_r[i] <= {`DW{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= ptr_t'(0);
      rd_ptr_r <= ptr_t'(0);
      count_r  <= cnt_t'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? ptr_t'(0) : wr_ptr_r + ptr_t'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? ptr_t'(0) : rd_ptr_r + ptr_t'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + cnt_t'(1);
        2'b01:   count_r <= count_r - cnt_t'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/input_vc_controller_base.sv
// Receiver-side controller for one input VC: flit buffering, IDLE/WAIT_VA/ACTIVE
// state machine and credit return. Optional INPUT_VC_OVF_CHK_EN adds sticky ovf_err/udf_err.
module input_vc_controller_base
  import input_vc_controller_base_pkg::*;
#(
  parameter logic [1:0] VCID         = 2'd0,
  parameter cnt_t       INIT_CREDITS = cnt_t'(`BUF_DEPTH - 1)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           valid,
  input  logic [`DW-1:0] data,
  output logic           credit_upd,
  output logic [`DW-1:0] flit_out,
  output logic           flit_out_valid,
  output logic           vaReq,
  input  logic           vaGrant,
  output logic           saReq,
  input  logic           pop,
  output logic [1:0]     state
`ifdef INPUT_VC_OVF_CHK_EN
  ,
  output logic           ovf_err,
  output logic           udf_err
`endif
);

  logic      push_s;
  logic      pop_s;
  logic      empty_s;
  logic [1:0] head_type_s;
  vc_state_e state_r;
  vc_state_e state_nxt_s;
  cnt_t      pending_r;
  cnt_t      pending_nxt_s;
  logic      issue_s;
  logic      credit_upd_r;

  // Link acceptance and effective pop.
  always_comb begin
    push_s      = valid & (data[`DW-1:`DW-2] == VCID);
    pop_s       = pop & ~empty_s;
    head_type_s = flit_type(flit_out);
  end

`ifdef INPUT_VC_OVF_CHK_EN
  logic push_drop_s;
  logic pop_empty_s;
  logic ovf_err_r;
  logic udf_err_r;

  vc_flit_fifo u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_s),
    .pop       (pop),
    .din       (data),
    .dout      (flit_out),
    .empty     (empty_s),
    .push_drop (push_drop_s),
    .pop_empty (pop_empty_s)
  );

  // Sticky protocol-violation flags, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_err_r <= 1'b0;
      udf_err_r <= 1'b0;
    end else begin
      ovf_err_r <= ovf_err_r | push_drop_s;
      udf_err_r <= udf_err_r | pop_empty_s;
    end
  end

  assign ovf_err = ovf_err_r;
  assign udf_err = udf_err_r;
`else
  vc_flit_fifo u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_s),
    .pop   (pop),
    .din   (data),
    .dout  (flit_out),
    .empty (empty_s)
  );
`endif

  // VC state next-state logic on the FIFO head.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s && is_head(head_type_s)) state_nxt_s = ST_WAIT_VA;
        else                                  state_nxt_s = ST_IDLE;
      end
      ST_WAIT_VA: begin
        if (vaGrant) state_nxt_s = ST_ACTIVE;
        else         state_nxt_s = ST_WAIT_VA;
      end
      ST_ACTIVE: begin
        if (pop_s && is_tail(head_type_s)) state_nxt_s = ST_IDLE;
        else                               state_nxt_s = ST_ACTIVE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // VC state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Pending credits: popped flits add, each issued credit cycle subtracts.
  always_comb begin
    issue_s       = (pending_r != cnt_t'(0));
    pending_nxt_s = pending_r;
    case ({pop_s, issue_s})
      2'b10:   pending_nxt_s = pending_r + cnt_t'(1);
      2'b01:   pending_nxt_s = pending_r - cnt_t'(1);
      default: pending_nxt_s = pending_r;
    endcase
  end

  // Credit counter and registered credit strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_r    <= INIT_CREDITS;
      credit_upd_r <= 1'b0;
    end else begin
      pending_r    <= pending_nxt_s;
      credit_upd_r <= issue_s;
    end
  end

  assign credit_upd     = credit_upd_r;
  assign flit_out_valid = ~empty_s;
  assign vaReq          = (state_r == ST_WAIT_VA);
  assign saReq          = (state_r == ST_ACTIVE) & ~empty_s;
  assign state          = state_r;

endmodule
